// File: rtl/alu_operand_sequencer_if.sv
// Handshake and gate-side signals of the operand sequencer.
// The master side is the environment and the slave side is the sequencer.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_ones;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [7:0]       op_count;

    modport master (
        output in_data, in_valid, y_in, res_ready,
        input  in_ready, a_out, b_out, res_data, res_zero, res_ones,
               res_valid, busy, op_count
    );

    modport slave (
        input  in_data, in_valid, y_in, res_ready,
        output in_ready, a_out, b_out, res_data, res_zero, res_ones,
               res_valid, busy, op_count
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Serial A/B operand loader around a combinational gate.
// The result is sampled after one settle cycle and held on a valid/ready port.
module alu_operand_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_operand_sequencer_if.slave bus
);
    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_zero_q,  res_zero_d;
    logic             res_ones_q,  res_ones_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       op_count_q,  op_count_d;
    logic             in_ready;
    logic             xfer;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign xfer     = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_ones_d  = res_ones_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            LOAD_A: begin
                if (xfer) begin
                    a_d     = bus.in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    b_d     = bus.in_data;
                    state_d = EXEC;
                end
            end
            // Operands have been stable on a_out/b_out for a full cycle here.
            EXEC: begin
                res_data_d  = bus.y_in;
                res_zero_d  = (bus.y_in == '0);
                res_ones_d  = (bus.y_in == '1);
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            default: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = LOAD_A;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_ones_q  <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_ones_q  <= res_ones_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q != LOAD_A);
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_ones  = res_ones_q;
    assign bus.res_valid = res_valid_q;
    assign bus.op_count  = op_count_q;
endmodule
